// File: rtl/rx_tstamp_extract.sv
// rtl/rx_tstamp_extract.sv - strips the 8-byte tx timestamp tail from rx frames and reports rtt
module rx_tstamp_extract #(
  parameter int MIN_PAYLOAD = 14,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           gmac_rx_data,
  input  logic                 gmac_rx_dvld,
  input  logic                 gmac_rx_goodframe,
  input  logic                 gmac_rx_badframe,
  input  logic [63:0]          count64,
  input  logic                 rx_tstamp_en,
  output logic [7:0]           out_data,
  output logic                 out_dvld,
  output logic                 out_eof,
  output logic                 out_good,
  output logic                 out_bad,
  output logic                 ts_valid,
  output logic [63:0]          tx_tstamp,
  output logic [63:0]          rx_tstamp,
  output logic [63:0]          rtt,
  output logic [CNT_WIDTH-1:0] ts_frame_cnt,
  output logic [CNT_WIDTH-1:0] runt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STRIP,
    S_PASS_THRU,
    S_END,
    S_DROP
  } state_t;

  // Frame must hold the 8-byte tail plus the minimum payload to yield a timestamp.
  localparam logic [16:0]          MIN_TOTAL = 17'(8 + MIN_PAYLOAD);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t      r_state;
  logic [63:0] r_dl;          // delay line; [63:56] is the oldest byte
  logic [15:0] r_cnt;         // bytes in current frame, saturating
  logic [63:0] r_rx_sample;   // count64 at first byte of current frame
  logic        r_pass;        // current frame is pass-through
  logic        r_egood;       // frame-end pulse was goodframe
  logic        r_first;       // first cycle after reset release

  logic        w_end;
  logic        w_good;
  logic [15:0] w_cnt_inc;
  logic        w_ts_ok;

  assign w_end     = gmac_rx_goodframe | gmac_rx_badframe;
  assign w_good    = gmac_rx_goodframe & ~gmac_rx_badframe;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_ts_ok   = ~r_pass & r_egood & ({1'b0, r_cnt} >= MIN_TOTAL);

  // Frame FSM: delay line, byte counting, forwarding and end-of-frame reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dl         <= '0;
      r_cnt        <= '0;
      r_rx_sample  <= '0;
      r_pass       <= 1'b0;
      r_egood      <= 1'b0;
      r_first      <= 1'b1;
      out_data     <= '0;
      out_dvld     <= 1'b0;
      out_eof      <= 1'b0;
      out_good     <= 1'b0;
      out_bad      <= 1'b0;
      ts_valid     <= 1'b0;
      tx_tstamp    <= '0;
      rx_tstamp    <= '0;
      rtt          <= '0;
      ts_frame_cnt <= '0;
      runt_cnt     <= '0;
    end else begin
      r_first  <= 1'b0;
      out_dvld <= 1'b0;
      out_eof  <= 1'b0;
      out_good <= 1'b0;
      out_bad  <= 1'b0;
      ts_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_END: begin
          if (r_state == S_END) begin
            r_state <= S_IDLE;
            out_eof <= 1'b1;
            if (r_pass) begin
              out_good <= r_egood;
              out_bad  <= ~r_egood;
            end else if (w_ts_ok) begin
              out_good     <= 1'b1;
              ts_valid     <= 1'b1;
              tx_tstamp    <= r_dl;
              rx_tstamp    <= r_rx_sample;
              rtt          <= r_rx_sample - r_dl;
              ts_frame_cnt <= ts_frame_cnt + CNT_ONE;
            end else begin
              out_bad <= 1'b1;
              if (r_egood) runt_cnt <= runt_cnt + CNT_ONE;
            end
          end
          // A new frame may start while the previous one is being closed out.
          if (gmac_rx_dvld) begin
            if (r_first) begin
              if (!w_end) r_state <= S_DROP;
            end else begin
              r_rx_sample <= count64;
              r_cnt       <= 16'd1;
              r_pass      <= ~rx_tstamp_en;
              r_dl        <= {56'd0, gmac_rx_data};
              if (!rx_tstamp_en) begin
                out_data <= gmac_rx_data;
                out_dvld <= 1'b1;
              end
              if (w_end) begin
                r_state <= S_END;
                r_egood <= w_good;
              end else begin
                r_state <= rx_tstamp_en ? S_FILL : S_PASS_THRU;
              end
            end
          end
        end
        S_FILL: begin
          if (gmac_rx_dvld) begin
            r_dl  <= {r_dl[55:0], gmac_rx_data};
            r_cnt <= w_cnt_inc;
            if (r_cnt == 16'd7) r_state <= S_STRIP;
          end
          if (w_end) begin
            r_state <= S_END;
            r_egood <= w_good;
          end
        end
        S_STRIP: begin
          if (gmac_rx_dvld) begin
            out_data <= r_dl[63:56];
            out_dvld <= 1'b1;
            r_dl     <= {r_dl[55:0], gmac_rx_data};
            r_cnt    <= w_cnt_inc;
          end
          if (w_end) begin
            r_state <= S_END;
            r_egood <= w_good;
          end
        end
        S_PASS_THRU: begin
          if (gmac_rx_dvld) begin
            out_data <= gmac_rx_data;
            out_dvld <= 1'b1;
            r_cnt    <= w_cnt_inc;
          end
          if (w_end) begin
            r_state <= S_END;
            r_egood <= w_good;
          end
        end
        S_DROP: begin
          if (w_end) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rx_tstamp_extract.md
Name: rx_tstamp_extract

Overview:
- Receive-side counterpart of the timestamp-appending TX queue in the rtt_probe project.
- Sits between the GMAC receive byte interface and the RX queue, in the rx core clock domain.
- Strips the 8-byte transmit timestamp that the far end appended to each frame, and forwards the remaining payload bytes.
- Reports the transmit timestamp, the local arrival timestamp and their difference (the round-trip time) once per frame.

Parameters:
- MIN_PAYLOAD, 14: minimum payload bytes, excluding the timestamp, for a frame to be valid.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  input  1  rx core clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- gmac_rx_data  input  8  received byte.
- gmac_rx_dvld  input  1  gmac_rx_data valid.
- gmac_rx_goodframe  input  1  one-cycle pulse: the frame just ended is good.
- gmac_rx_badframe  input  1  one-cycle pulse: the frame just ended is bad.
- count64  input  64  free-running timestamp counter (clk domain).
- rx_tstamp_en  input  1  1 = strip and report; 0 = transparent pass-through.
- out_data  output  8  payload byte.
- out_dvld  output  1  out_data valid.
- out_eof  output  1  one-cycle end-of-frame pulse, issued after the last payload byte.
- out_good  output  1  qualifies out_eof: frame good.
- out_bad  output  1  qualifies out_eof: frame bad.
- ts_valid  output  1  one-cycle pulse: tx_tstamp, rx_tstamp and rtt are valid.
- tx_tstamp  output  64  timestamp extracted from the frame tail.
- rx_tstamp  output  64  count64 sampled on the frame's first byte.
- rtt  output  64  rx_tstamp - tx_tstamp, modulo 2^64.
- ts_frame_cnt  output  CNT_WIDTH  frames with ts_valid issued.
- runt_cnt  output  CNT_WIDTH  frames rejected as too short.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, delay line cleared.
- Tail format: the last 8 received bytes are the TX timestamp, big-endian (first byte of the tail = bits 63:56).
- Delay line: 8-byte shift register. A byte is forwarded only once 8 newer bytes have arrived, so the last 8 bytes of a frame are never forwarded.
- Forwarding latency: input byte N appears on out_data, with out_dvld=1, one clk after input byte N+8 is accepted.
- Byte counter: 16 bits, saturating at 0xFFFF, cleared at start of frame.
- Frame end: a gmac_rx_goodframe or gmac_rx_badframe pulse.
  - If gmac_rx_dvld is high in the same cycle, that byte is the frame's last byte.
  - The next frame may start at the earliest one cycle after the pulse.
- gmac_rx_dvld gaps mid-frame (no end pulse): state holds; nothing is forwarded during the gap.
- States:
  - IDLE: on gmac_rx_dvld, sample rx_tstamp <= count64, load the byte, clear the byte counter (then count it), and sample rx_tstamp_en. Go to FILL if enabled, else PASS_THRU.
  - FILL: buffer bytes with no output until 8 bytes are held, then go to STRIP.
  - STRIP: each accepted byte shifts the oldest delay-line byte out to out_data.
  - PASS_THRU: each byte goes to out_data one clk later; the delay line is unused.
  - END: entered on a frame-end pulse from FILL, STRIP or PASS_THRU. Taken one clk after the pulse (after the last forwarded byte, if any):
    - Always: out_eof=1 and return to IDLE.
    - STRIP with goodframe and byte count >= 8+MIN_PAYLOAD: tx_tstamp = delay-line contents, rtt = rx_tstamp - tx_tstamp, ts_valid=1, out_good=1, ts_frame_cnt+1.
    - From FILL, or STRIP with count < 8+MIN_PAYLOAD: out_bad=1, ts_valid=0, runt_cnt+1. Buffered bytes are discarded.
    - Badframe: out_bad=1, ts_valid=0, counters unchanged.
    - PASS_THRU: out_good/out_bad mirror the frame-end pulse; ts_valid=0.
  - DROP: entered from IDLE if gmac_rx_dvld is high in the first cycle after reset deassertion (mid-frame). Discard all bytes until a frame-end pulse, then go to IDLE. No out_eof.
- Register retention: tx_tstamp, rx_tstamp and rtt hold their values until the next ts_valid.
- Counters: ts_frame_cnt and runt_cnt wrap at 2^CNT_WIDTH.
- Reset assertion mid-frame: immediate return to reset values; no out_eof is emitted for the aborted frame.
- rx_tstamp_en changes mid-frame take effect at the next frame start.

Test Plan:
- 30-byte good frame with tail 00_00_00_00_00_00_10_00; count64=0x1500 at the first byte. Expected:
  - 22 bytes forwarded.
  - out_eof with out_good.
  - ts_valid with tx_tstamp=0x1000, rx_tstamp=0x1500, rtt=0x500.
  - ts_frame_cnt=1.
- Wrap case: tail FF_FF_FF_FF_FF_FF_FF_F0, count64=0x10 at the first byte -> rtt=0x20.
- 20-byte good frame (12 payload < 14) -> 12 bytes forwarded, out_eof with out_bad, no ts_valid, runt_cnt=1. Repeat with a 5-byte frame -> 0 bytes forwarded, out_eof with out_bad, runt_cnt=2.
- 30-byte frame ending in badframe -> 22 bytes forwarded, out_bad, no ts_valid, counters unchanged.
- rx_tstamp_en=0, 30-byte good frame -> all 30 bytes forwarded, each with 1-cycle latency; out_good; no ts_valid.
- Gap and reset cases:
  - 3-cycle gmac_rx_dvld gap inside a 40-byte frame -> output stream identical to the gapless case; timestamp correct.
  - reset_n pulsed low at byte 15 of a frame -> outputs go 0 immediately.
  - Remaining bytes of that frame are dropped, with no out_eof.
  - The next frame is processed normally.
